// File: rtl/prod_accum_pkg.sv
// rtl/prod_accum_pkg.sv - shared types and default constants for the product accumulator
// Purpose: frame FSM state encoding and default parameter values used by prod_accum.
// Ports: none (package).
package prod_accum_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DATA_W_DEF = 16;
  localparam int COUNT_DEF  = 8;
  localparam int ACC_W_DEF  = 20;

endpackage

// File: rtl/prod_accum_sat_add.sv
// rtl/prod_accum_sat_add.sv - combinational unsigned saturating adder
// Purpose: sum_o = min(a_i + b_i, 2^A_W - 1); carry_o flags that the clamp was applied.
// Ports:
//   a_i     [A_W-1:0]  unsigned addend (accumulator side)
//   b_i     [B_W-1:0]  unsigned addend, zero-extended; B_W must not exceed A_W
//   sum_o   [A_W-1:0]  saturated sum
//   carry_o            carry out of the A_W-bit add (saturation happened)
module sat_add #(
  parameter int A_W = 20,
  parameter int B_W = 16
) (
  input  logic [A_W-1:0] a_i,
  input  logic [B_W-1:0] b_i,
  output logic [A_W-1:0] sum_o,
  output logic           carry_o
);

  // One extra bit holds the carry so the clamp decision is exact.
  logic [A_W:0] full_sum;

  assign full_sum = {1'b0, a_i} + (A_W + 1)'(b_i);
  assign carry_o  = full_sum[A_W];
  assign sum_o    = carry_o ? {A_W{1'b1}} : full_sum[A_W-1:0];

endmodule

// File: rtl/prod_accum.sv
// rtl/prod_accum.sv - per-frame saturating accumulator of multiplier products
// Purpose: sums COUNT accepted products per frame and holds the result on an output handshake.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     product handshake, in_data [DATA_W-1:0] unsigned product
//   out_valid/out_ready   frame-sum handshake, result held while out_ready is low
//   out_sum [ACC_W-1:0]   saturated frame sum, out_ovf sticky saturation flag
//   busy                  a frame has started and has not yet been delivered
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int COUNT  = COUNT_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf,
  output logic              busy
);

  generate
    if (COUNT < 1 || COUNT > 16 || ACC_W < DATA_W) begin : g_bad_params
      $error("prod_accum: COUNT must be 1..16 and ACC_W >= DATA_W");
    end
  endgenerate

  localparam int CNT_W = $clog2(COUNT + 1);
  // Count value held just before the frame-closing beat.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              ovf_q, ovf_d;

  logic [ACC_W-1:0]  add_sum;
  logic              add_carry;
  logic              beat;

  sat_add #(
    .A_W (ACC_W),
    .B_W (DATA_W)
  ) u_sat_add (
    .a_i     (acc_q),
    .b_i     (in_data),
    .sum_o   (add_sum),
    .carry_o (add_carry)
  );

  // Handshake outputs are decoded from state alone: no path from in_valid/out_ready.
  assign in_ready  = (state_q != DONE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == ACC) || (state_q == DONE);
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;
  assign beat      = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (beat) begin
          // First beat loads rather than adds, so no saturation is possible here.
          acc_d   = ACC_W'(in_data);
          count_d = CNT_W'(1);
          ovf_d   = 1'b0;
          state_d = (COUNT == 1) ? DONE : ACC;
        end
      end
      ACC: begin
        if (beat) begin
          acc_d   = add_sum;
          ovf_d   = ovf_q | add_carry;
          count_d = count_q + 1'b1;
          if (count_q == LAST_CNT) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        count_d = '0;
        ovf_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
